dual_edge_pipe: RTL and testbench

Multi-channel, parametrised-depth dual-edge delay pipeline; next generation of the single-stage dual-edge flip-flop. Each of `CHANNELS` lanes is a `DEPTH`-stage shift line of dual-edge registers. The lane advances on posedge, negedge or both, as set by a per-lane mode. Each stage carries a valid bit, with per-lane flush and occupancy reporting. Sits between DDR-style capture logic and SDR consumers that need half-cycle-granular alignment.

---
 rtl/dual_edge_pipe_pkg.sv | 15 +
 rtl/dual_edge_stage.sv | 55 +++++
 rtl/dual_edge_pipe.sv | 91 +++++++++
 tb/tb_dual_edge_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_edge_pipe_pkg.sv
// Shared constants and helpers for the dual-edge delay pipeline.
package dual_edge_pipe_pkg;

  // Per-lane advance mode: bit0 enables posedge, bit1 enables negedge.
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_POS  = 2'b01;
  localparam logic [1:0] MODE_NEG  = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Bits needed to count 0..depth valid stages.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dual_edge_stage.sv
// One WIDTH-bit dual-edge register built from a posedge half (p) and a negedge
// half (n); the stored value is p ^ n, so either edge can overwrite it by
// writing its own half relative to the other.
module dual_edge_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,     // synchronous, sampled on both edges
  input  logic             pos_en_i,
  input  logic             neg_en_i,
  input  logic             clr_i,      // posedge-only clear to zero
  input  logic [WIDTH-1:0] rst_val_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] p_d, p_q;
  logic [WIDTH-1:0] n_d, n_q;

  // Posedge half next state: reset loads the reset value (n is cleared by the
  // negedge half), clear makes p equal n so the pair reads zero.
  always_comb begin
    p_d = p_q;
    if (!rst_ni) begin
      p_d = rst_val_i;
    end else if (clr_i) begin
      p_d = n_q;
    end else if (pos_en_i) begin
      p_d = d_i ^ n_q;
    end
  end

  // Negedge half next state.
  always_comb begin
    n_d = n_q;
    if (!rst_ni) begin
      n_d = '0;
    end else if (neg_en_i) begin
      n_d = d_i ^ p_q;
    end
  end

  // Posedge half register.
  always_ff @(posedge clk_i) begin
    p_q <= p_d;
  end

  // Negedge half register.
  always_ff @(negedge clk_i) begin
    n_q <= n_d;
  end

  assign q_o = p_q ^ n_q;

endmodule

// File: rtl/dual_edge_pipe.sv
// Multi-lane dual-edge delay pipeline. Each lane is a DEPTH-stage shift line of
// dual-edge registers with a valid tag per stage, advancing on the edges its
// mode selects, with a posedge flush of the valid tags and an occupancy count.
module dual_edge_pipe
  import dual_edge_pipe_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH  = 8,
  parameter int unsigned            CHANNELS    = 4,
  parameter int unsigned            DEPTH       = 4,
  parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [2*CHANNELS-1:0]                  ch_mode,
  input  logic [CHANNELS*DATA_WIDTH-1:0]         data_in,
  input  logic [CHANNELS-1:0]                    valid_in,
  input  logic [CHANNELS-1:0]                    flush,
  output logic [CHANNELS*DATA_WIDTH-1:0]         data_out,
  output logic [CHANNELS-1:0]                    valid_out,
  output logic [CHANNELS*occ_width(DEPTH)-1:0]   occupancy
);

  localparam int unsigned OccW = occ_width(DEPTH);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic [1:0]            lane_mode;
    logic                  pos_en;
    logic                  neg_en;
    logic [DATA_WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0]      stage_v;
    logic [OccW-1:0]       occ;

    assign lane_mode = ch_mode[2*c +: 2];
    assign pos_en    = |(lane_mode & MODE_POS);
    assign neg_en    = |(lane_mode & MODE_NEG);

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic [DATA_WIDTH-1:0] d_src;
      logic                  v_src;

      if (k == 0) begin : g_head
        assign d_src = data_in[c*DATA_WIDTH +: DATA_WIDTH];
        assign v_src = valid_in[c];
      end else begin : g_body
        assign d_src = stage_d[k-1];
        assign v_src = stage_v[k-1];
      end

      // Data is never flushed; only the valid tags are.
      dual_edge_stage #(
        .WIDTH (DATA_WIDTH)
      ) u_data (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .pos_en_i  (pos_en),
        .neg_en_i  (neg_en),
        .clr_i     (1'b0),
        .rst_val_i (RESET_VALUE),
        .d_i       (d_src),
        .q_o       (stage_d[k])
      );

      // Clear wins over a same-posedge advance, so a flushed lane reads empty.
      dual_edge_stage #(
        .WIDTH (1)
      ) u_valid (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .pos_en_i  (pos_en),
        .neg_en_i  (neg_en),
        .clr_i     (flush[c]),
        .rst_val_i (1'b0),
        .d_i       (v_src),
        .q_o       (stage_v[k])
      );
    end

    // Popcount of the lane's valid tags.
    always_comb begin
      occ = '0;
      for (int k = 0; k < DEPTH; k++) begin
        occ = occ + OccW'(stage_v[k]);
      end
    end

    assign data_out[c*DATA_WIDTH +: DATA_WIDTH] = stage_d[DEPTH-1];
    assign valid_out[c]                         = stage_v[DEPTH-1];
    assign occupancy[c*OccW +: OccW]            = occ;
  end

endmodule

// File: tb/tb_dual_edge_pipe.sv
// Self-checking bench for dual_edge_pipe against a lane-level shift model.
module tb_dual_edge_pipe;

  localparam int DW = 8;
  localparam int CH = 4;
  localparam int DP = 4;
  localparam int OW = $clog2(DP + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2*CH-1:0]   ch_mode;
  logic [CH*DW-1:0]  data_in;
  logic [CH-1:0]     valid_in;
  logic [CH-1:0]     flush;
  logic [CH*DW-1:0]  data_out;
  logic [CH-1:0]     valid_out;
  logic [CH*OW-1:0]  occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: per lane, stage contents from entry (0) to exit (DP-1).
  logic [DW-1:0] m_d [CH][DP];
  logic          m_v [CH][DP];

  dual_edge_pipe #(
    .DATA_WIDTH  (DW),
    .CHANNELS    (CH),
    .DEPTH       (DP),
    .RESET_VALUE (8'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_mode   (ch_mode),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .flush     (flush),
    .data_out  (data_out),
    .valid_out (valid_out),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] m_occ(input int c);
    int n = 0;
    for (int k = 0; k < DP; k++) n += int'(m_v[c][k]);
    return OW'(n);
  endfunction

  // Apply one clock edge to the model using the inputs the DUT samples.
  function automatic void model_edge(input bit pos);
    for (int c = 0; c < CH; c++) begin
      if (!rst_n) begin
        for (int k = 0; k < DP; k++) begin
          m_d[c][k] = '0;
          m_v[c][k] = 1'b0;
        end
      end else begin
        if (pos ? ch_mode[2*c] : ch_mode[2*c+1]) begin
          for (int k = DP - 1; k > 0; k--) begin
            m_d[c][k] = m_d[c][k-1];
            m_v[c][k] = m_v[c][k-1];
          end
          m_d[c][0] = data_in[c*DW +: DW];
          m_v[c][0] = valid_in[c];
        end
        if (pos && flush[c]) begin
          for (int k = 0; k < DP; k++) m_v[c][k] = 1'b0;
        end
      end
    end
  endfunction

  // Wait for the next edge, update the model, return 1 ns later.
  task automatic next_edge(output bit pos);
    @(posedge clk or negedge clk);
    pos = (clk === 1'b1);
    model_edge(pos);
    #1;
  endtask

  task automatic set_lane(input int c, input logic [DW-1:0] d, input logic v);
    data_in[c*DW +: DW] = d;
    valid_in[c]         = v;
  endtask

  task automatic test_reset();
    bit pos;
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      next_edge(pos);
      ch_mode  = 8'($urandom);
      data_in  = $urandom;
      valid_in = 4'($urandom);
      flush    = 4'($urandom);
    end
    for (int c = 0; c < CH; c++) begin
      n_cmp++;
      if (data_out[c*DW +: DW] !== 8'h00 || valid_out[c] !== 1'b0 ||
          occupancy[c*OW +: OW] !== OW'(0)) begin
        n_bad++;
        $display("FAIL reset lane%0d: got d=%h v=%b occ=%0d, want d=00 v=0 occ=0",
                 c, data_out[c*DW +: DW], valid_out[c], occupancy[c*OW +: OW]);
      end
    end
    flush = '0;
  endtask

  task automatic test_pos_mode();
    bit pos;
    int npos = 0;
    logic [DW-1:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    ch_mode = 8'b00_00_00_01;
    flush   = '0;
    set_lane(0, words[0], 1'b1);
    rst_n   = 1'b1;
    for (int i = 0; i < 12; i++) begin
      next_edge(pos);
      for (int c = 0; c < CH; c++) begin
        n_cmp++;
        if (data_out[c*DW +: DW] !== m_d[c][DP-1] || valid_out[c] !== m_v[c][DP-1] ||
            occupancy[c*OW +: OW] !== m_occ(c)) begin
          n_bad++;
          $display("FAIL pos_mode lane%0d: got d=%h v=%b occ=%0d, want d=%h v=%b occ=%0d",
                   c, data_out[c*DW +: DW], valid_out[c], occupancy[c*OW +: OW],
                   m_d[c][DP-1], m_v[c][DP-1], m_occ(c));
        end
      end
      if (pos) begin
        npos++;
        if (npos == 4) begin
          n_cmp++;
          if (data_out[7:0] !== 8'h11 || occupancy[OW-1:0] !== OW'(4)) begin
            n_bad++;
            $display("FAIL pos_4th_edge: got d=%h occ=%0d, want d=11 occ=4",
                     data_out[7:0], occupancy[OW-1:0]);
          end
        end
        if (npos < 4) set_lane(0, words[npos], 1'b1);
        else set_lane(0, 8'($urandom), 1'b1);
      end
    end
  endtask

  task automatic test_both_mode();
    bit pos;
    ch_mode = 8'b00_00_11_00;
    set_lane(1, 8'hA0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      next_edge(pos);
      for (int c = 0; c < CH; c++) begin
        n_cmp++;
        if (data_out[c*DW +: DW] !== m_d[c][DP-1] || valid_out[c] !== m_v[c][DP-1] ||
            occupancy[c*OW +: OW] !== m_occ(c)) begin
          n_bad++;
          $display("FAIL both_mode lane%0d: got d=%h v=%b occ=%0d, want d=%h v=%b occ=%0d",
                   c, data_out[c*DW +: DW], valid_out[c], occupancy[c*OW +: OW],
                   m_d[c][DP-1], m_v[c][DP-1], m_occ(c));
        end
      end
      if (i >= DP && i < DP + 8) begin
        n_cmp++;
        if (data_out[15:8] !== 8'(8'hA0 + i - DP)) begin
          n_bad++;
          $display("FAIL both_seq edge%0d: got %h, want %h", i, data_out[15:8],
                   8'(8'hA0 + i - DP));
        end
      end
      set_lane(1, 8'(8'hA0 + i), 1'b1);
    end
  endtask

  task automatic test_mixed();
    bit pos;
    logic [DW-1:0] hold_d;
    logic [OW-1:0] hold_occ;
    hold_d   = m_d[3][DP-1];
    hold_occ = m_occ(3);
    ch_mode  = 8'b00_11_10_01;
    for (int c = 0; c < CH; c++) set_lane(c, 8'h5A, 1'b1);
    for (int i = 0; i < 12; i++) begin
      next_edge(pos);
      for (int c = 0; c < CH; c++) begin
        n_cmp++;
        if (data_out[c*DW +: DW] !== m_d[c][DP-1] || valid_out[c] !== m_v[c][DP-1] ||
            occupancy[c*OW +: OW] !== m_occ(c)) begin
          n_bad++;
          $display("FAIL mixed lane%0d: got d=%h v=%b occ=%0d, want d=%h v=%b occ=%0d",
                   c, data_out[c*DW +: DW], valid_out[c], occupancy[c*OW +: OW],
                   m_d[c][DP-1], m_v[c][DP-1], m_occ(c));
        end
      end
    end
    n_cmp++;
    if (data_out[31:24] !== hold_d || occupancy[3*OW +: OW] !== hold_occ) begin
      n_bad++;
      $display("FAIL mixed_hold lane3: got d=%h occ=%0d, want d=%h occ=%0d",
               data_out[31:24], occupancy[3*OW +: OW], hold_d, hold_occ);
    end
  endtask

  task automatic test_flush();
    bit pos;
    int npos = 0;
    ch_mode = 8'b00_00_00_01;
    for (int i = 0; i < 20; i++) begin
      next_edge(pos);
      for (int c = 0; c < CH; c++) begin
        n_cmp++;
        if (data_out[c*DW +: DW] !== m_d[c][DP-1] || valid_out[c] !== m_v[c][DP-1] ||
            occupancy[c*OW +: OW] !== m_occ(c)) begin
          n_bad++;
          $display("FAIL flush lane%0d: got d=%h v=%b occ=%0d, want d=%h v=%b occ=%0d",
                   c, data_out[c*DW +: DW], valid_out[c], occupancy[c*OW +: OW],
                   m_d[c][DP-1], m_v[c][DP-1], m_occ(c));
        end
      end
      if (pos) begin
        npos++;
        if (npos == 5) begin
          n_cmp++;
          if (occupancy[OW-1:0] !== OW'(4)) begin
            n_bad++;
            $display("FAIL flush_full: got occ=%0d, want 4", occupancy[OW-1:0]);
          end
          flush[0] = 1'b1;
        end else if (npos == 6) begin
          n_cmp++;
          if (occupancy[OW-1:0] !== OW'(0) || valid_out[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_clear: got occ=%0d v=%b, want occ=0 v=0",
                     occupancy[OW-1:0], valid_out[0]);
          end
          flush[0] = 1'b0;
          ch_mode  = 8'b00_00_00_11;
        end
        set_lane(0, 8'($urandom), 1'b1);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit pos;
    ch_mode = 8'hFF;
    for (int c = 0; c < CH; c++) set_lane(c, 8'($urandom), 1'b0);
    for (int i = 0; i < 7; i++) begin
      next_edge(pos);
      if (i >= 3) for (int c = 0; c < CH; c++) set_lane(c, 8'($urandom), 1'b1);
    end
    n_cmp++;
    if (occupancy[2*OW +: OW] !== OW'(3)) begin
      n_bad++;
      $display("FAIL mid_occ3 lane2: got %0d, want 3", occupancy[2*OW +: OW]);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_edge(pos);
      data_in = $urandom;
      valid_in = 4'($urandom);
    end
    for (int c = 0; c < CH; c++) begin
      n_cmp++;
      if (data_out[c*DW +: DW] !== 8'h00 || valid_out[c] !== 1'b0 ||
          occupancy[c*OW +: OW] !== OW'(0)) begin
        n_bad++;
        $display("FAIL mid_reset lane%0d: got d=%h v=%b occ=%0d, want d=00 v=0 occ=0",
                 c, data_out[c*DW +: DW], valid_out[c], occupancy[c*OW +: OW]);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < CH; c++) set_lane(c, 8'h7E, 1'b1);
    for (int i = 1; i <= DP; i++) begin
      next_edge(pos);
      n_cmp++;
      if (occupancy[2*OW +: OW] !== OW'(i)) begin
        n_bad++;
        $display("FAIL mid_rise edge%0d: got occ=%0d, want %0d", i,
                 occupancy[2*OW +: OW], i);
      end
      for (int c = 0; c < CH; c++) set_lane(c, 8'($urandom), 1'b1);
    end
    n_cmp++;
    if (data_out[23:16] !== 8'h7E || valid_out[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_first_word: got d=%h v=%b, want d=7e v=1",
               data_out[23:16], valid_out[2]);
    end
  endtask

  task automatic test_random();
    bit pos;
    for (int i = 0; i < 400; i++) begin
      next_edge(pos);
      for (int c = 0; c < CH; c++) begin
        n_cmp++;
        if (data_out[c*DW +: DW] !== m_d[c][DP-1] || valid_out[c] !== m_v[c][DP-1] ||
            occupancy[c*OW +: OW] !== m_occ(c)) begin
          n_bad++;
          $display("FAIL random edge%0d lane%0d: got d=%h v=%b occ=%0d, want d=%h v=%b occ=%0d",
                   i, c, data_out[c*DW +: DW], valid_out[c], occupancy[c*OW +: OW],
                   m_d[c][DP-1], m_v[c][DP-1], m_occ(c));
        end
      end
      if ($urandom_range(0, 7) == 0) ch_mode = 8'($urandom);
      data_in  = $urandom;
      valid_in = 4'($urandom);
      for (int c = 0; c < CH; c++) flush[c] = ($urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < DP; k++) begin
        m_d[c][k] = '0;
        m_v[c][k] = 1'b0;
      end
    end
    rst_n    = 1'b0;
    ch_mode  = '0;
    data_in  = '0;
    valid_in = '0;
    flush    = '0;
    test_reset();
    test_pos_mode();
    test_both_mode();
    test_mixed();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
